start_load_sequencer: RTL
=========================

START_LOAD_SEQUENCER -- requirements
Module: start_load_sequencer

Interface
REQ-001 SHALL have parameter data_size, default 16, meaning the width of one fixed-point lane.
REQ-002 SHALL have parameter size, default 3, meaning the lanes per word and the number of rows.
REQ-003 SHALL have parameter max_layer_size, default 5, meaning the maximum addresses per row.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports cmd_start (input, 1), cmd_layer_size (input, 32), cmd_data_set (input, 32) and cmd_ready (output, 1): the command request and its acceptance.
REQ-007 SHALL have outputs load (1), load_address (32), load_row (32), load_data_set (32) and reset_counter (1): the storage read request.
REQ-008 SHALL have input load_data, data_size*size bits: the combinational product returned for the current load request.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, data_size*size), out_row (output, 32), out_address (output, 32) and out_last (output, 1): the output stream.
REQ-010 SHALL have outputs done (1) and error (1): one-cycle status pulses.

Function
REQ-011 SHALL implement a state machine with states IDLE, RUN and DRAIN.
REQ-012 SHALL drive cmd_ready=1 only in IDLE.
REQ-013 SHALL accept a command on any cycle in IDLE with cmd_start=1 and 1<=cmd_layer_size<=max_layer_size.
  - On acceptance: latch layer_size and data_set, set row=0 and address=0, pulse reset_counter for that cycle, and go to RUN.
REQ-014 SHALL reject a command in IDLE whose cmd_layer_size is 0 or greater than max_layer_size.
  - On rejection: pulse error one cycle after cmd_start, stay in IDLE, and issue no load, reset_counter or done.
REQ-015 SHALL ignore cmd_start outside IDLE.
REQ-016 SHALL traverse row-major in RUN: row 0..size-1 outer, address 0..layer_size-1 inner; total size*layer_size loads.
REQ-017 SHALL assert load in RUN only when issue space exists.
  - Issue space: FIFO occupancy <2, or occupancy ==2 while a pop happens in the same cycle.
  - While load=1, drive load_row and load_address with the current indices and load_data_set with the latched data_set.
REQ-018 SHALL, in the same cycle load=1, push load_data together with its row, address and a last flag into a 2-entry FIFO, then advance the indices.
  - The last flag is set on the final (size-1, layer_size-1) element.
REQ-019 SHALL hold load at 0, and drive load_address, load_row and load_data_set at 0, whenever it is not issuing.
REQ-020 SHALL go from RUN to DRAIN on the cycle it issues the final element.
REQ-021 SHALL present the FIFO head on out_data, out_row, out_address and out_last with out_valid=1 whenever the FIFO is non-empty.
  - A pop occurs when out_valid and out_ready are both 1.
  - Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL pulse done one cycle after the pop of the element with out_last=1, and go from DRAIN to IDLE in that same cycle.
REQ-023 SHALL give its latency relative to the acceptance edge T:
  - first load in cycle T+1;
  - first out_valid in cycle T+2;
  - with out_ready held at 1: one element per cycle and no bubbles.
REQ-024 SHALL treat load_data as opaque bits: no arithmetic and no width change.
REQ-025 SHALL handle a simultaneous push and pop at occupancy 2 with occupancy staying 2 and element order preserved.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force the following, independent of clk:
  - state IDLE, FIFO empty and indices 0;
  - out_valid, load, reset_counter, done and error at 0;
  - all data, address and row outputs at 0;
  - cmd_ready at 1.
REQ-027 SHALL, on reset assertion mid-operation, discard any in-flight command and buffered data; no done pulse follows.
REQ-028 SHALL accept a command on the first rising clk after reset_n deasserts.

Verification
REQ-029 SHALL cover the normal sequence.
  - Stimulus: size=3, cmd_layer_size=2, cmd_data_set=7, out_ready=1.
  - Response: loads (r0,a0),(r0,a1),(r1,a0),(r1,a1),(r2,a0),(r2,a1) in six consecutive cycles, each with load_data_set=7; out_last only on (r2,a1); done one cycle later.
REQ-030 SHALL cover backpressure.
  - Stimulus: cmd_layer_size=5, out_ready=0 for 10 cycles.
  - Response: exactly 2 loads issued, then load=0 and out_data held stable; after out_ready=1, the remaining 13 elements follow in order.
REQ-031 SHALL cover rejection.
  - Stimulus: cmd_layer_size=0, and separately cmd_layer_size=6.
  - Response: error pulses once for each; load, reset_counter and done stay 0; cmd_ready stays 1.
REQ-032 SHALL cover reset mid-operation.
  - Stimulus: reset_n=0 after the third load.
  - Response: out_valid=0 immediately with no clock edge; no done; a new command with layer_size=1 gives 3 elements in order.
REQ-033 SHALL cover a busy command.
  - Stimulus: cmd_start=1 with layer_size=4 during RUN.
  - Response: cmd_ready=0, the command is ignored, and the original run completes with unchanged order and count.
REQ-034 SHALL check data passthrough.
  - Stimulus: the model returns load_data = {row,address,data_set} encoded per lane.
  - Response: every out_data matches the encoding for its out_row and out_address.

Source files
------------

// File: rtl/start_load_sequencer_if.sv
// Command, storage-load and output-stream signals of the start/load sequencer.
// The sequencer takes the slave side; the environment driving it takes the master side.
interface start_load_sequencer_if #(
   parameter int data_size = 16,
   parameter int size      = 3
);
   logic                        cmd_start;
   logic [31:0]                 cmd_layer_size;
   logic [31:0]                 cmd_data_set;
   logic                        cmd_ready;

   logic                        load;
   logic [31:0]                 load_address;
   logic [31:0]                 load_row;
   logic [31:0]                 load_data_set;
   logic                        reset_counter;
   logic [data_size*size-1:0]   load_data;

   // out_* handshake: an element moves on a cycle where out_valid and out_ready are both 1.
   // While out_valid=1 and out_ready=0 the element stays unchanged.
   logic                        out_valid;
   logic                        out_ready;
   logic [data_size*size-1:0]   out_data;
   logic [31:0]                 out_row;
   logic [31:0]                 out_address;
   logic                        out_last;

   logic                        done;
   logic                        error;

   modport slave (
      input  cmd_start, cmd_layer_size, cmd_data_set, load_data, out_ready,
      output cmd_ready, load, load_address, load_row, load_data_set, reset_counter,
      output out_valid, out_data, out_row, out_address, out_last, done, error
   );

   modport master (
      output cmd_start, cmd_layer_size, cmd_data_set, load_data, out_ready,
      input  cmd_ready, load, load_address, load_row, load_data_set, reset_counter,
      input  out_valid, out_data, out_row, out_address, out_last, done, error
   );
endinterface

// File: rtl/start_load_sequencer.sv
// Walks rows x addresses of a layer, issuing storage loads and streaming the
// returned words through a 2-entry FIFO with row/address/last tags.
module start_load_sequencer #(
   parameter int data_size      = 16,
   parameter int size           = 3,
   parameter int max_layer_size = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   start_load_sequencer_if.slave   bus,
   output logic [1:0]              dbg_state
);
   localparam int DW = data_size * size;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     layer_size_q, layer_size_d;
   logic [31:0]     data_set_q, data_set_d;
   logic [31:0]     row_q, row_d;
   logic [31:0]     addr_q, addr_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic [DW-1:0]   fifo_data_q [2];
   logic [DW-1:0]   fifo_data_d [2];
   logic [31:0]     fifo_row_q  [2];
   logic [31:0]     fifo_row_d  [2];
   logic [31:0]     fifo_addr_q [2];
   logic [31:0]     fifo_addr_d [2];
   logic            fifo_last_q [2];
   logic            fifo_last_d [2];
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      count_q, count_d;

   logic            cmd_ok;
   logic            accept;
   logic            pop;
   logic            issue;
   logic            last_elem;

   assign cmd_ok    = (bus.cmd_layer_size != 32'd0) &&
                      (bus.cmd_layer_size <= 32'(max_layer_size));
   // reset_counter is combinational, so keep it quiet while reset is held.
   assign accept    = reset_n && (state_q == IDLE) && bus.cmd_start && cmd_ok;
   assign pop       = (count_q != 2'd0) && bus.out_ready;
   // A pop in the same cycle frees the slot a full FIFO needs for this push.
   assign issue     = (state_q == RUN) && ((count_q != 2'd2) || pop);
   assign last_elem = (row_q == 32'(size - 1)) && (addr_q == layer_size_q - 32'd1);

   always_comb begin
      state_d      = state_q;
      layer_size_d = layer_size_q;
      data_set_d   = data_set_q;
      row_d        = row_q;
      addr_d       = addr_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      fifo_data_d  = fifo_data_q;
      fifo_row_d   = fifo_row_q;
      fifo_addr_d  = fifo_addr_q;
      fifo_last_d  = fifo_last_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + {1'b0, issue} - {1'b0, pop};

      case (state_q)
         IDLE: begin
            if (bus.cmd_start) begin
               if (cmd_ok) begin
                  layer_size_d = bus.cmd_layer_size;
                  data_set_d   = bus.cmd_data_set;
                  row_d        = 32'd0;
                  addr_d       = 32'd0;
                  state_d      = RUN;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (issue) begin
               if (last_elem) begin
                  row_d   = 32'd0;
                  addr_d  = 32'd0;
                  state_d = DRAIN;
               end else if (addr_q == layer_size_q - 32'd1) begin
                  row_d  = row_q + 32'd1;
                  addr_d = 32'd0;
               end else begin
                  addr_d = addr_q + 32'd1;
               end
            end
         end
         DRAIN: begin
            if (pop && fifo_last_q[rd_ptr_q]) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         fifo_data_d[wr_ptr_q] = bus.load_data;
         fifo_row_d[wr_ptr_q]  = row_q;
         fifo_addr_d[wr_ptr_q] = addr_q;
         fifo_last_d[wr_ptr_q] = last_elem;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         layer_size_q <= '0;
         data_set_q   <= '0;
         row_q        <= '0;
         addr_q       <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_row_q[i]  <= '0;
            fifo_addr_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         state_q      <= state_d;
         layer_size_q <= layer_size_d;
         data_set_q   <= data_set_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         done_q       <= done_d;
         error_q      <= error_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= fifo_data_d[i];
            fifo_row_q[i]  <= fifo_row_d[i];
            fifo_addr_q[i] <= fifo_addr_d[i];
            fifo_last_q[i] <= fifo_last_d[i];
         end
      end
   end

   assign bus.cmd_ready     = (state_q == IDLE);
   assign bus.load          = issue;
   assign bus.load_row      = issue ? row_q      : 32'd0;
   assign bus.load_address  = issue ? addr_q     : 32'd0;
   assign bus.load_data_set = issue ? data_set_q : 32'd0;
   assign bus.reset_counter = accept;

   assign bus.out_valid     = (count_q != 2'd0);
   assign bus.out_data      = fifo_data_q[rd_ptr_q];
   assign bus.out_row       = fifo_row_q[rd_ptr_q];
   assign bus.out_address   = fifo_addr_q[rd_ptr_q];
   assign bus.out_last      = fifo_last_q[rd_ptr_q];

   assign bus.done          = done_q;
   assign bus.error         = error_q;
   assign dbg_state         = state_q;
endmodule
